// File: rtl/fetch_sequencer.sv
// Fetch-stage PC and IF/ID sequencer: BOOT -> RUN -> HALT, 1-cycle capture, 1-bubble redirect.
// Define FETCH_BOUNDS_CHECK_EN to halt with a sticky fault on an out-of-range fetch.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        halted,
    output logic        fault,
    output logic [15:0] fetch_count
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        out_of_range;

    assign pc_plus4 = pc + 32'd4;
    assign imem_pc  = pc;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;
    logic fault_q;
    assign out_of_range = ({1'b0, pc} >= PC_LIMIT);
    assign fault        = fault_q;
`else
    logic [31:0] unused_imem_words;
    assign unused_imem_words = 32'(IMEM_WORDS);
    assign out_of_range      = 1'b0;
    assign fault             = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            ifid_valid  <= 1'b0;
            ifid_instr  <= 32'h0;
            ifid_pc4    <= 32'h0;
            halted      <= 1'b0;
            fetch_count <= 16'h0;
`ifdef FETCH_BOUNDS_CHECK_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            case (state)
                BOOT: begin
                    state      <= RUN;
                    ifid_valid <= 1'b0;
                end
                RUN: begin
                    if (redirect) begin
                        // Squash the wrong-path word; IF/ID payload is left as-is.
                        pc         <= {redirect_pc[31:2], 2'b00};
                        ifid_valid <= 1'b0;
                    end else if (out_of_range) begin
                        state      <= HALT;
                        halted     <= 1'b1;
                        ifid_valid <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
                        fault_q    <= 1'b1;
`endif
                    end else if (halt_req) begin
                        state      <= HALT;
                        halted     <= 1'b1;
                        ifid_valid <= 1'b0;
                    end else if (!stall) begin
                        ifid_instr  <= imem_instr;
                        ifid_pc4    <= pc_plus4;
                        ifid_valid  <= 1'b1;
                        pc          <= pc_plus4;
                        fetch_count <= fetch_count + 16'd1;
                    end
                end
                default: begin
                    ifid_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
